seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DWELL, default 100000: clock cycles per digit slot; legal range DWELL >= GUARD+1.
REQ-002 SHALL have parameter GUARD, default 2: all-anodes-off cycles at the start of each slot (anti-ghosting); legal range GUARD >= 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port value, input, 16 bits: four hex nibbles, with digit k = value[4k+3:4k].
REQ-006 SHALL have port dp_in, input, 4 bits: decimal point per digit, 1 = lit.
REQ-007 SHALL have port blank_in, input, 4 bits: per-digit blank, 1 = digit dark.
REQ-008 SHALL have port load, input, 1 bit: capture value/dp_in/blank_in into the pending register.
REQ-009 SHALL have port pending, output, 1 bit: captured data not yet displayed.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse after each frame boundary.
REQ-011 SHALL have port an, output, 4 bits: anode enables, active-low, an[k] = digit k.
REQ-012 SHALL have port ssd, output, 8 bits: segments, active-low; ssd[0..7] = A,B,C,D,E,F,G,DP.

Function
REQ-013 SHALL hold slot counter cnt (0..DWELL-1) and digit index dig (0..3); cnt increments every cycle.
REQ-014 At cnt==DWELL-1 SHALL set cnt to 0 and advance dig (3 wraps to 0).
REQ-015 Frame boundary SHALL be defined as the edge where dig==3 and cnt==DWELL-1.
REQ-016 SHALL keep display registers disp_val/disp_dp/disp_blank and pending registers pend_val/pend_dp/pend_blank.
REQ-017 On an edge with load=1, SHALL copy the inputs to the pend registers and set pending=1; a later load before the boundary SHALL overwrite (last wins).
REQ-018 On a frame-boundary edge with pending=1, SHALL copy the pre-edge pend contents to the disp registers and clear pending.
REQ-019 When load and a frame boundary coincide, SHALL apply the old pend to disp, capture the new inputs into pend, and leave pending=1 (the new data is shown after the next boundary).
REQ-020 Displayed data SHALL change only at frame boundaries; no frame may mix old and new nibbles.
REQ-021 an SHALL be 4'b1111 while cnt<GUARD, or while disp_blank[dig]=1.
REQ-022 Otherwise an SHALL be all ones except an[dig]=0.
REQ-023 ssd SHALL be the active-low glyph of disp_val nibble dig; ssd[7] SHALL be ~disp_dp[dig].
REQ-024 ssd SHALL be 8'hFF whenever an==4'b1111.
REQ-025 Lit segments per nibble SHALL be: 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG, 4 BCFG, 5 ACDFG, 6 ACDEFG, 7 ABC, 8 ABCDEFG, 9 ABCDFG, A ABCEFG, b CDEFG, C ADEF, d BCDEG, E ADEFG, F AEFG.
REQ-026 an and ssd SHALL be decoded from the current registered state (cnt, dig, disp) with zero added latency, and SHALL be glitch-free registered outputs updated on the same edge as that state.
REQ-027 frame_done SHALL be registered and equal 1 for exactly the cycle following each frame-boundary edge, independent of pending.
REQ-028 Counter width SHALL be $clog2(DWELL), with no overflow for any legal DWELL.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force: cnt=0, dig=0, disp_val=0, disp_dp=0, disp_blank=4'b1111, all pend registers 0, pending=0, frame_done=0, an=4'b1111, ssd=8'hFF.
REQ-030 After rst_n deasserts, scanning SHALL start at digit 0, cnt 0, on the first rising edge; the display stays dark until the first applied load.

Verification (DWELL=8, GUARD=2; frame = 32 cycles)
REQ-031 Reset, then run 40 cycles with no load -> an=4'b1111 and ssd=8'hFF throughout; frame_done pulses once per 32 cycles.
REQ-032 Load value=16'h12AF, dp_in=0, blank_in=0 at cycle 3 -> pending=1 until the boundary at cycle 31. Then, per slot, cycles 0-1 give an=1111, and cycles 2-7 give:
- digit 0: an=1110, ssd=8'h8E
- digit 1: an=1101, ssd=8'h88
- digit 2: an=1011, ssd=8'hA4
- digit 3: an=0111, ssd=8'hF9
REQ-033 Same as REQ-032 but dp_in=4'b0100 -> digit 2 ssd=8'h24; the other digits are unchanged.
REQ-034 Two loads in one frame (16'h1111, then 16'h2222) -> only 16'h2222 is ever displayed.
REQ-035 Load exactly on the boundary edge while pending holds 16'h00AA -> 16'h00AA is shown for one frame, then the new value; pending stays 1 across that boundary.
REQ-036 blank_in=4'b0010 applied, then rst_n pulsed low mid-slot -> an=1111 and ssd=FF asynchronously, and pending=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner.
// Each digit gets DWELL clocks. The first GUARD clocks of every slot keep
// all anodes off. New data is staged in a pending register and moves to
// the display registers only at frame boundaries, so a frame never shows
// a mix of old and new digits. an/ssd are registered from the next-state
// decode, so they always match the registered cnt/dig/disp state with no
// extra latency and without glitches.
module seg_scan_driver #(
   parameter int DWELL = 100000,
   parameter int GUARD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        load,
   output logic        pending,
   output logic        frame_done,
   output logic [3:0]  an,
   output logic [7:0]  ssd
);

   localparam int          CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST  = CW'(DWELL - 1);
   localparam logic [31:0] GUARD_U = 32'(GUARD);

   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    dig, dig_n;
   logic [15:0]   disp_val, disp_val_n, pend_val;
   logic [3:0]    disp_dp, disp_dp_n, pend_dp;
   logic [3:0]    disp_blank, disp_blank_n, pend_blank;
   logic          wrap, boundary;
   logic [3:0]    an_n;
   logic [7:0]    ssd_n;
   logic [3:0]    nib;

   // Active-high segment pattern, bit0 = A ... bit6 = G
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   // Next scan position, display latch at boundary, and output decode of that next state
   always_comb begin
      wrap         = (cnt == LAST);
      boundary     = wrap && (dig == 2'd3);
      cnt_n        = wrap ? '0 : cnt + 1'b1;
      dig_n        = wrap ? dig + 2'd1 : dig;
      disp_val_n   = disp_val;
      disp_dp_n    = disp_dp;
      disp_blank_n = disp_blank;
      if (boundary && pending) begin
         disp_val_n   = pend_val;
         disp_dp_n    = pend_dp;
         disp_blank_n = pend_blank;
      end
      nib   = disp_val_n[4*dig_n +: 4];
      an_n  = 4'hF;
      ssd_n = 8'hFF;
      if (!((32'(cnt_n) < GUARD_U) || disp_blank_n[dig_n])) begin
         an_n         = 4'hF;
         an_n[dig_n]  = 1'b0;
         ssd_n        = {~disp_dp_n[dig_n], ~glyph(nib)};
      end
   end

   // Scan counters, display/pending registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         dig        <= 2'd0;
         disp_val   <= 16'h0;
         disp_dp    <= 4'h0;
         disp_blank <= 4'hF;
         pend_val   <= 16'h0;
         pend_dp    <= 4'h0;
         pend_blank <= 4'h0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         an         <= 4'hF;
         ssd        <= 8'hFF;
      end else begin
         cnt        <= cnt_n;
         dig        <= dig_n;
         disp_val   <= disp_val_n;
         disp_dp    <= disp_dp_n;
         disp_blank <= disp_blank_n;
         frame_done <= boundary;
         an         <= an_n;
         ssd        <= ssd_n;
         // A load on the boundary edge re-arms pending with the new data
         if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pending    <= 1'b1;
         end else if (boundary) begin
            pending    <= 1'b0;
         end
      end
   end

endmodule
